// File: rtl/prbs31_pkg.sv
// prbs31_pkg: shared types and constants
// for the PRBS31 stream checker.
package prbs31_pkg;

  typedef enum logic [1:0] {
    ST_SEED = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2,
    ST_LOST = 2'd3
  } state_t;

  localparam int PRBS_W = 31;
  localparam int TAP_A  = 30;
  localparam int TAP_B  = 27;

  localparam int DEF_LOCK_MATCHES = 64;
  localparam int DEF_WINDOW       = 32;
  localparam int DEF_LOSS_ERRS    = 4;

endpackage

// File: rtl/prbs31_sat_cnt16.sv
// prbs31_sat_cnt16: 16-bit saturating
// error counter with synchronous clear.
module prbs31_sat_cnt16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt,
  output logic        sat
);

  assign sat = &cnt;

  // clear wins over a same-edge increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/tt_um_davidparent_prbs31_chk.sv
// tt_um_davidparent_prbs31_chk: serial
// PRBS31 checker with lock tracking.
module tt_um_davidparent_prbs31_chk
  import prbs31_pkg::*;
#(
  parameter int LOCK_MATCHES = DEF_LOCK_MATCHES,
  parameter int WINDOW       = DEF_WINDOW,
  parameter int LOSS_ERRS    = DEF_LOSS_ERRS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int BW = $clog2(PRBS_W);
  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(LOSS_ERRS + 1);

  localparam logic [BW-1:0] B_LAST = BW'(PRBS_W - 1);
  localparam logic [MW-1:0] M_LAST = MW'(LOCK_MATCHES - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WINDOW - 1);
  localparam logic [EW-1:0] E_LAST = EW'(LOSS_ERRS - 1);

  logic rx, vld, clr, bsel;
  assign rx   = ui_in[0];
  assign vld  = ui_in[1];
  assign clr  = ui_in[2];
  assign bsel = ui_in[3];

  logic unused;
  assign unused = &{1'b0, ena, ui_in[7:4], uio_in};

  state_t            st, st_n;
  logic [PRBS_W-1:0] s, s_n;
  logic [BW-1:0]     bcnt, bcnt_n;
  logic [MW-1:0]     mcnt, mcnt_n;
  logic [WW-1:0]     wpos, wpos_n;
  logic [EW-1:0]     werr, werr_n;
  logic              locked, err_pulse;
  logic              pulse_n, hit;
  logic              pred, mis, wrap;
  logic [15:0]       err_cnt;
  logic              cnt_sat;

  assign pred = s[TAP_A] ^ s[TAP_B];
  assign mis  = rx ^ pred;
  assign wrap = (wpos == W_LAST);

  // next-state for FSM, history and
  // counters; all hold when no bit is valid
  always_comb begin
    st_n    = st;
    s_n     = s;
    bcnt_n  = bcnt;
    mcnt_n  = mcnt;
    wpos_n  = wpos;
    werr_n  = werr;
    hit     = 1'b0;
    pulse_n = 1'b0;
    if (vld) begin
      unique case (st)
        ST_SEED: begin
          s_n = {s[PRBS_W-2:0], rx};
          if (bcnt == B_LAST) begin
            st_n   = ST_ACQ;
            bcnt_n = '0;
            mcnt_n = '0;
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
        end
        ST_ACQ: begin
          s_n = {s[PRBS_W-2:0], rx};
          if (!mis && (s != '0)) begin
            if (mcnt == M_LAST) begin
              st_n   = ST_LOCK;
              mcnt_n = '0;
              wpos_n = '0;
              werr_n = '0;
            end else begin
              mcnt_n = mcnt + 1'b1;
            end
          end else begin
            mcnt_n = '0;
          end
        end
        ST_LOCK: begin
          s_n     = {s[PRBS_W-2:0], pred};
          hit     = mis;
          pulse_n = mis;
          wpos_n  = wrap ? '0 : wpos + 1'b1;
          if (mis && (werr == E_LAST)) begin
            st_n   = ST_LOST;
            wpos_n = '0;
            werr_n = '0;
          end else if (wrap) begin
            werr_n = '0;
          end else if (mis) begin
            werr_n = werr + 1'b1;
          end
        end
        ST_LOST: begin
          s_n    = {s[PRBS_W-2:0], rx};
          st_n   = ST_SEED;
          bcnt_n = '0;
          mcnt_n = '0;
        end
      endcase
    end
  end

  // state, history, counters and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_SEED;
      s         <= '0;
      bcnt      <= '0;
      mcnt      <= '0;
      wpos      <= '0;
      werr      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      st        <= st_n;
      s         <= s_n;
      bcnt      <= bcnt_n;
      mcnt      <= mcnt_n;
      wpos      <= wpos_n;
      werr      <= werr_n;
      locked    <= (st_n == ST_LOCK);
      err_pulse <= pulse_n;
    end
  end

  prbs31_sat_cnt16 u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (hit),
    .cnt   (err_cnt),
    .sat   (cnt_sat)
  );

  assign uo_out  = {3'b000, cnt_sat, st, err_pulse, locked};
  assign uio_out = bsel ? err_cnt[15:8] : err_cnt[7:0];
  assign uio_oe  = 8'hFF;

endmodule
